game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Game flow sequencer: tracks lives and level, freezes motion during the
// death and level-up animations, and raises game over when lives run out.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for the first start press after reset/restart
// PLAY      | frog and traffic moving, hits and top-row arrivals counted
// DYING     | frozen for DEATH_CYCLES after a hit with lives remaining
// LEVEL_UP  | frozen for LEVELUP_CYCLES after reaching the top row
// GAME_OVER | lives exhausted, waiting for start to begin a new game
module game_sequencer #(
   parameter int START_LIVES    = 3,
   parameter int MAX_LEVEL      = 99,
   parameter int DEATH_CYCLES   = 50_000_000,
   parameter int LEVELUP_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   input  logic       start_btn,
   input  logic       frog_at_top,
   input  logic       frog_hit,
   output logic [2:0] state,
   output logic [1:0] lives,
   output logic [6:0] level,
   output logic       reset_frog,
   output logic       level_up,
   output logic       freeze,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLAY      = 3'd1,
      DYING     = 3'd2,
      LEVEL_UP  = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   localparam logic [1:0]  LIVES_INIT   = 2'(START_LIVES);
   localparam logic [6:0]  LEVEL_MAX    = 7'(MAX_LEVEL);
   localparam logic [31:0] DEATH_LOAD   = 32'(DEATH_CYCLES - 1);
   localparam logic [31:0] LEVELUP_LOAD = 32'(LEVELUP_CYCLES - 1);

   state_t      r_state;
   logic [1:0]  r_lives;
   logic [6:0]  r_level;
   logic [31:0] r_timer;
   logic        r_start_prev;
   logic        r_reset_frog;
   logic        r_level_up;
   logic        r_freeze;
   logic        r_game_over;
   logic        w_start_edge;

   assign w_start_edge = start_btn & ~r_start_prev;

   // Game state machine; every output is updated together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_lives      <= LIVES_INIT;
         r_level      <= 7'd1;
         r_timer      <= '0;
         r_start_prev <= 1'b0;
         r_reset_frog <= 1'b0;
         r_level_up   <= 1'b0;
         r_freeze     <= 1'b1;
         r_game_over  <= 1'b0;
      end else begin
         r_start_prev <= start_btn;
         r_reset_frog <= 1'b0;
         r_level_up   <= 1'b0;
         if (restart) begin
            r_state      <= IDLE;
            r_lives      <= LIVES_INIT;
            r_level      <= 7'd1;
            r_timer      <= '0;
            r_reset_frog <= 1'b1;
            r_freeze     <= 1'b1;
            r_game_over  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_start_edge) begin
                     r_state      <= PLAY;
                     r_lives      <= LIVES_INIT;
                     r_level      <= 7'd1;
                     r_reset_frog <= 1'b1;
                     r_freeze     <= 1'b0;
                  end
               end
               PLAY: begin
                  // A hit outranks a simultaneous top-row arrival.
                  if (frog_hit) begin
                     r_freeze <= 1'b1;
                     if (r_lives > 2'd1) begin
                        r_lives <= r_lives - 2'd1;
                        r_state <= DYING;
                        r_timer <= DEATH_LOAD;
                     end else begin
                        r_lives     <= 2'd0;
                        r_state     <= GAME_OVER;
                        r_game_over <= 1'b1;
                     end
                  end else if (frog_at_top) begin
                     if (r_level < LEVEL_MAX) begin
                        r_level <= r_level + 7'd1;
                     end
                     r_state    <= LEVEL_UP;
                     r_timer    <= LEVELUP_LOAD;
                     r_level_up <= 1'b1;
                     r_freeze   <= 1'b1;
                  end
               end
               DYING, LEVEL_UP: begin
                  if (r_timer == 32'd0) begin
                     r_state      <= PLAY;
                     r_reset_frog <= 1'b1;
                     r_freeze     <= 1'b0;
                  end else begin
                     r_timer <= r_timer - 32'd1;
                  end
               end
               GAME_OVER: begin
                  if (w_start_edge) begin
                     r_state      <= PLAY;
                     r_lives      <= LIVES_INIT;
                     r_level      <= 7'd1;
                     r_reset_frog <= 1'b1;
                     r_freeze     <= 1'b0;
                     r_game_over  <= 1'b0;
                  end
               end
               default: begin
                  r_state     <= IDLE;
                  r_timer     <= '0;
                  r_freeze    <= 1'b1;
                  r_game_over <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state      = r_state;
   assign lives      = r_lives;
   assign level      = r_level;
   assign reset_frog = r_reset_frog;
   assign level_up   = r_level_up;
   assign freeze     = r_freeze;
   assign game_over  = r_game_over;

endmodule
